// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter + scoreboard: merges two writeback requesters onto one register-file write port.
// Latency: one cycle from grant to We/Wr/D; scoreboard updates at the grant edge.
// Backpressure: a requester holds Valid until its Ready; losing requester waits, one write per cycle.
//
// Ports:
//   Clk, Rst            single clock, synchronous active-high reset
//   AValid/AReady/AReg/AData   requester A (ALU result)
//   BValid/BReady/BReg/BData   requester B (load unit)
//   ClaimVld/ClaimReg          issue stage reserves a destination register
//   Ra, Rb, Stall              source registers in issue and the resulting hazard flag
//   Busy                       scoreboard vector, bit i = register i has a pending write
//   We, Wr, D                  registered register-file write port
//
// Build option: define WB_RR_ARB_EN for round-robin arbitration between A and B;
// without it A has fixed priority over B.

module regfile_wb_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              AValid,
    output logic              AReady,
    input  logic [4:0]        AReg,
    input  logic [DATA_W-1:0] AData,

    input  logic              BValid,
    output logic              BReady,
    input  logic [4:0]        BReg,
    input  logic [DATA_W-1:0] BData,

    input  logic              ClaimVld,
    input  logic [4:0]        ClaimReg,

    input  logic [4:0]        Ra,
    input  logic [4:0]        Rb,
    output logic              Stall,
    output logic [31:0]       Busy,

    output logic              We,
    output logic [4:0]        Wr,
    output logic [DATA_W-1:0] D
);

    logic              grant_a;
    logic              grant_b;
    logic              xfer_a;
    logic              xfer_b;
    logic              xfer;
    logic [4:0]        xfer_reg;
    logic [DATA_W-1:0] xfer_dat;

    logic [31:0]       busy_q;
    logic [31:0]       busy_nxt;

    logic              we_q;
    logic [4:0]        wr_q;
    logic [DATA_W-1:0] d_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef WB_RR_ARB_EN
    // rr_ptr_q names the requester that wins a conflict: 0 = A, 1 = B.
    logic rr_ptr_q;

    always_comb begin
        grant_a = AValid & (~BValid | ~rr_ptr_q);
        grant_b = BValid & (~AValid |  rr_ptr_q);
    end

    // After any transfer the preference passes to the other requester,
    // so a held conflict alternates A, B, A, B.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_ptr_q <= 1'b0;
        end else if (xfer_a) begin
            rr_ptr_q <= 1'b1;
        end else if (xfer_b) begin
            rr_ptr_q <= 1'b0;
        end
    end
`else
    // Fixed priority: A always wins, B only proceeds when A is idle.
    always_comb begin
        grant_a = AValid;
        grant_b = BValid & ~AValid;
    end
`endif

    // Reset blocks all grants so nothing in flight is accepted.
    assign AReady = grant_a & ~Rst;
    assign BReady = grant_b & ~Rst;

    assign xfer_a = AValid & AReady;
    assign xfer_b = BValid & BReady;
    assign xfer   = xfer_a | xfer_b;

    // At most one grant is high, so a simple select is enough.
    assign xfer_reg = xfer_a ? AReg  : BReg;
    assign xfer_dat = xfer_a ? AData : BData;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Clear for the granted writeback first, then apply the claim so that
    // a same-cycle claim of the same register leaves the bit set: the new
    // instruction's pending write is the one that matters.
    always_comb begin
        busy_nxt = busy_q;
        if (xfer) begin
            busy_nxt[xfer_reg] = 1'b0;
        end
        if (ClaimVld) begin
            busy_nxt[ClaimReg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;  // r0 is hardwired, never pending
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign Busy = busy_q;

    // Hazard check looks only at the registered scoreboard; a write being
    // granted this cycle still stalls the reader until the next cycle.
    // busy_q[0] is always 0, so r0 sources never stall.
    assign Stall = busy_q[Ra] | busy_q[Rb];

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    // Writes to r0 are accepted from the requester but suppressed here;
    // Wr/D keep their previous values whenever no real write happens.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q <= 1'b0;
            wr_q <= '0;
            d_q  <= '0;
        end else if (xfer && (xfer_reg != 5'd0)) begin
            we_q <= 1'b1;
            wr_q <= xfer_reg;
            d_q  <= xfer_dat;
        end else begin
            we_q <= 1'b0;
        end
    end

    assign We = we_q;
    assign Wr = wr_q;
    assign D  = d_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: table of per-cycle vectors plus
// hand-written sequences for arbitration conflicts and back-to-back writes.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked on the falling edge, registered outputs 1 time unit after the next rising edge.

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;

    logic              Clk;
    logic              Rst;
    logic              AValid;
    logic              AReady;
    logic [4:0]        AReg;
    logic [DATA_W-1:0] AData;
    logic              BValid;
    logic              BReady;
    logic [4:0]        BReg;
    logic [DATA_W-1:0] BData;
    logic              ClaimVld;
    logic [4:0]        ClaimReg;
    logic [4:0]        Ra;
    logic [4:0]        Rb;
    logic              Stall;
    logic [31:0]       Busy;
    logic              We;
    logic [4:0]        Wr;
    logic [DATA_W-1:0] D;

    int total;
    int bad;

    regfile_wb_arbiter #(.DATA_W(DATA_W)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .AValid   (AValid),
        .AReady   (AReady),
        .AReg     (AReg),
        .AData    (AData),
        .BValid   (BValid),
        .BReady   (BReady),
        .BReg     (BReg),
        .BData    (BData),
        .ClaimVld (ClaimVld),
        .ClaimReg (ClaimReg),
        .Ra       (Ra),
        .Rb       (Rb),
        .Stall    (Stall),
        .Busy     (Busy),
        .We       (We),
        .Wr       (Wr),
        .D        (D)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  areg;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  breg;
        logic [31:0] bdat;
        logic        cv;
        logic [4:0]  creg;
        logic [4:0]  ra;
        logic [4:0]  rb;
        // expected during the cycle (before the edge)
        logic        e_ar;
        logic        e_br;
        logic        e_stall;
        // expected after the edge
        logic        e_we;
        logic        chk_wd;
        logic [4:0]  e_wr;
        logic [31:0] e_d;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] areg, input logic [31:0] adat,
        input logic bv, input logic [4:0] breg, input logic [31:0] bdat,
        input logic cv, input logic [4:0] creg, input logic [4:0] ra, input logic [4:0] rb,
        input logic e_ar, input logic e_br, input logic e_stall,
        input logic e_we, input logic chk_wd, input logic [4:0] e_wr, input logic [31:0] e_d,
        input logic [31:0] e_busy);
        vec_t v;
        v.rst = rst; v.av = av; v.areg = areg; v.adat = adat;
        v.bv = bv; v.breg = breg; v.bdat = bdat;
        v.cv = cv; v.creg = creg; v.ra = ra; v.rb = rb;
        v.e_ar = e_ar; v.e_br = e_br; v.e_stall = e_stall;
        v.e_we = e_we; v.chk_wd = chk_wd; v.e_wr = e_wr; v.e_d = e_d; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        Rst      = v.rst;
        AValid   = v.av;
        AReg     = v.areg;
        AData    = v.adat;
        BValid   = v.bv;
        BReg     = v.breg;
        BData    = v.bdat;
        ClaimVld = v.cv;
        ClaimReg = v.creg;
        Ra       = v.ra;
        Rb       = v.rb;
    endtask

    task automatic idle();
        Rst = 1'b0; AValid = 1'b0; AReg = '0; AData = '0;
        BValid = 1'b0; BReg = '0; BData = '0;
        ClaimVld = 1'b0; ClaimReg = '0; Ra = '0; Rb = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //              rst av areg adat          bv breg bdat          cv creg ra  rb   ar br st  we ck wr  d             busy
        tbl[0]  = mk(1, 1, 5,  32'h1234,      0, 0,  32'h0,         0, 0,  0,  0,   0, 0, 0,  0, 1, 0,  32'h0,        32'h0);
        tbl[1]  = mk(0, 1, 5,  32'h1234,      0, 0,  32'h0,         0, 0,  0,  0,   1, 0, 0,  1, 1, 5,  32'h1234,     32'h0);
        tbl[2]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  0,  0,   0, 0, 0,  0, 1, 5,  32'h1234,     32'h0);
        tbl[3]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 7,  0,  0,   0, 0, 0,  0, 1, 5,  32'h1234,     32'h80);
        tbl[4]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  7,  0,   0, 0, 1,  0, 1, 5,  32'h1234,     32'h80);
        tbl[5]  = mk(0, 0, 0,  32'h0,         1, 7,  32'hBEEF,      0, 0,  7,  0,   0, 1, 1,  1, 1, 7,  32'hBEEF,     32'h0);
        tbl[6]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  7,  0,   0, 0, 0,  0, 1, 7,  32'hBEEF,     32'h0);
        tbl[7]  = mk(0, 1, 0,  32'hFFFF,      0, 0,  32'h0,         0, 0,  0,  0,   1, 0, 0,  0, 0, 0,  32'h0,        32'h0);
        tbl[8]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 0,  0,  0,   0, 0, 0,  0, 0, 0,  32'h0,        32'h0);
        tbl[9]  = mk(0, 1, 9,  32'h99,        0, 0,  32'h0,         1, 9,  0,  0,   1, 0, 0,  1, 1, 9,  32'h99,       32'h200);
        tbl[10] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 3,  0,  9,   0, 0, 1,  0, 1, 9,  32'h99,       32'h208);
        tbl[11] = mk(0, 1, 3,  32'h33,        0, 0,  32'h0,         0, 0,  3,  0,   1, 0, 1,  1, 1, 3,  32'h33,       32'h200);
        tbl[12] = mk(1, 1, 4,  32'h44,        0, 0,  32'h0,         0, 0,  0,  0,   0, 0, 0,  0, 1, 0,  32'h0,        32'h0);
        tbl[13] = mk(0, 0, 0,  32'h0,         1, 31, 32'hA5A5A5A5,  1, 31, 0,  0,   0, 1, 0,  1, 1, 31, 32'hA5A5A5A5, 32'h8000_0000);
        tbl[14] = mk(0, 0, 0,  32'h0,         1, 31, 32'h1,         0, 0,  31, 0,   0, 1, 1,  1, 1, 31, 32'h1,        32'h0);
        tbl[15] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  31, 0,   0, 0, 0,  0, 1, 31, 32'h1,        32'h0);

        drive(tbl[0]);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            @(negedge Clk);
            chk($sformatf("v%0d AReady", i), {63'b0, AReady}, {63'b0, tbl[i].e_ar});
            chk($sformatf("v%0d BReady", i), {63'b0, BReady}, {63'b0, tbl[i].e_br});
            chk($sformatf("v%0d Stall", i),  {63'b0, Stall},  {63'b0, tbl[i].e_stall});
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d We", i),   {63'b0, We},   {63'b0, tbl[i].e_we});
            chk($sformatf("v%0d Busy", i), {32'b0, Busy}, {32'b0, tbl[i].e_busy});
            if (tbl[i].chk_wd) begin
                chk($sformatf("v%0d Wr", i), {59'b0, Wr}, {59'b0, tbl[i].e_wr});
                chk($sformatf("v%0d D", i),  {32'b0, D},  {32'b0, tbl[i].e_d});
            end
        end

        // Conflict: both requesters held for four cycles after a reset.
        idle();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        idle();
        AValid = 1'b1; AReg = 5'd1; AData = 32'h11;
        BValid = 1'b1; BReg = 5'd2; BData = 32'h22;
        for (int i = 0; i < 4; i++) begin
            logic       ear;
            logic       ebr;
            logic [4:0] ewr;
`ifdef WB_RR_ARB_EN
            ear = (i % 2 == 0);
            ebr = (i % 2 == 1);
            ewr = (i % 2 == 0) ? 5'd1 : 5'd2;
`else
            ear = 1'b1;
            ebr = 1'b0;
            ewr = 5'd1;
`endif
            @(negedge Clk);
            chk($sformatf("arb%0d AReady", i), {63'b0, AReady}, {63'b0, ear});
            chk($sformatf("arb%0d BReady", i), {63'b0, BReady}, {63'b0, ebr});
            @(posedge Clk);
            #1;
            chk($sformatf("arb%0d We", i), {63'b0, We}, 64'd1);
            chk($sformatf("arb%0d Wr", i), {59'b0, Wr}, {59'b0, ewr});
        end

        // Back-to-back writes from A: one write per cycle, no bubbles.
        idle();
        for (int i = 0; i < 4; i++) begin
            AValid = 1'b1;
            AReg   = 5'(10 + i);
            AData  = 32'hC000 + 32'(i);
            @(negedge Clk);
            chk($sformatf("b2b%0d AReady", i), {63'b0, AReady}, 64'd1);
            @(posedge Clk);
            #1;
            chk($sformatf("b2b%0d We", i), {63'b0, We}, 64'd1);
            chk($sformatf("b2b%0d Wr", i), {59'b0, Wr}, 64'(10 + i));
            chk($sformatf("b2b%0d D", i),  {32'b0, D},  64'(32'hC000 + i));
        end
        idle();
        @(posedge Clk);
        #1;
        chk("b2b_end We", {63'b0, We}, 64'd0);
        chk("b2b_end Wr", {59'b0, Wr}, 64'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
